// File: rtl/pwm_dt_core.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dt_core
// Brief    : N-channel phase-offset complementary PWM with dead-time insertion
//            and double-buffered config that swaps at the period boundary.
//            Optional feature macro: PWM_DT_FAULT_EN (sticky fault shutdown).
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dt_core #(
    parameter int N_CHANNELS = 4,
    parameter int CNT_DW     = 16,
    parameter int DEAD_DW    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [CNT_DW-1:0]            period_i,
    input  logic [N_CHANNELS*CNT_DW-1:0] duty_i,
    input  logic [N_CHANNELS*CNT_DW-1:0] phase_i,
    input  logic [DEAD_DW-1:0]           dead_i,
    input  logic                         cfg_update_i,
`ifdef PWM_DT_FAULT_EN
    input  logic                         fault_i,
    input  logic                         fault_clr_i,
    output logic                         fault_o,
`endif
    output logic                         cfg_pending_o,
    output logic                         cycle_start_o,
    output logic [N_CHANNELS-1:0]        pwm_hi_o,
    output logic [N_CHANNELS-1:0]        pwm_lo_o
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_LO_ON   = 3'd1,
        ST_DT_RISE = 3'd2,
        ST_HI_ON   = 3'd3,
        ST_DT_FALL = 3'd4
    } state_t;

    localparam logic [CNT_DW-1:0]  c_cnt_one  = CNT_DW'(1);
    localparam logic [CNT_DW:0]    c_ext_one  = (CNT_DW+1)'(1);
    localparam logic [DEAD_DW:0]   c_dead_one = (DEAD_DW+1)'(1);

    logic                         w_run;
    logic                         w_kill;
    logic                         w_wrap;
    logic                         w_swap;

    logic [CNT_DW-1:0]            r_cnt;
    logic                         r_cycle_start;
    logic                         r_pending;

    logic [CNT_DW-1:0]            r_stg_period, r_act_period;
    logic [N_CHANNELS*CNT_DW-1:0] r_stg_duty,   r_act_duty;
    logic [N_CHANNELS*CNT_DW-1:0] r_stg_phase,  r_act_phase;
    logic [DEAD_DW-1:0]           r_stg_dead,   r_act_dead;

`ifdef PWM_DT_FAULT_EN
    logic r_fault;

    // Set has priority so a clear can never mask a fault that is still present.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fault <= 1'b0;
        end else if (fault_i) begin
            r_fault <= 1'b1;
        end else if (fault_clr_i) begin
            r_fault <= 1'b0;
        end
    end

    assign fault_o = r_fault;
    assign w_run   = en_i & ~r_fault;
    assign w_kill  = r_fault;
`else
    assign w_run   = en_i;
    assign w_kill  = 1'b0;
`endif

    assign w_wrap = w_run && (r_cnt == r_act_period);
    assign w_swap = r_pending && (w_wrap || !w_run);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt         <= '0;
            r_cycle_start <= 1'b0;
        end else begin
            r_cycle_start <= w_run && (r_cnt == '0);
            if (!w_run || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // Staging always takes a fresh update; active only loads at a boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stg_period <= '0;
            r_stg_duty   <= '0;
            r_stg_phase  <= '0;
            r_stg_dead   <= '0;
            r_act_period <= '0;
            r_act_duty   <= '0;
            r_act_phase  <= '0;
            r_act_dead   <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_swap) begin
                r_act_period <= r_stg_period;
                r_act_duty   <= r_stg_duty;
                r_act_phase  <= r_stg_phase;
                r_act_dead   <= r_stg_dead;
            end
            if (cfg_update_i) begin
                r_stg_period <= period_i;
                r_stg_duty   <= duty_i;
                r_stg_phase  <= phase_i;
                r_stg_dead   <= dead_i;
                r_pending    <= 1'b1;
            end else if (w_swap) begin
                r_pending    <= 1'b0;
            end
        end
    end

    assign cfg_pending_o = r_pending;
    assign cycle_start_o = r_cycle_start;

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
        logic [CNT_DW:0]    w_p, w_cnt_x, w_duty, w_phase, w_ph, w_s;
        logic               w_raw;
        logic               w_dead_zero;
        logic               w_dt_done;
        state_t             r_state, w_next;
        logic [DEAD_DW-1:0] r_dcnt, w_dcnt_next;
        logic               r_hi, r_lo;

        assign w_p     = {1'b0, r_act_period};
        assign w_cnt_x = {1'b0, r_cnt};
        assign w_duty  = {1'b0, r_act_duty[gi*CNT_DW +: CNT_DW]};
        assign w_phase = {1'b0, r_act_phase[gi*CNT_DW +: CNT_DW]};
        assign w_ph    = (w_phase > w_p) ? w_p : w_phase;
        assign w_s     = (w_cnt_x >= w_ph) ? (w_cnt_x - w_ph)
                                           : (w_cnt_x + w_p + c_ext_one - w_ph);
        assign w_raw   = (w_duty == '0) ? 1'b0 :
                         (w_duty > w_p) ? 1'b1 : (w_s < w_duty);

        // ">=" rather than "==" so a dead time shrunk at a swap cannot strand dcnt.
        assign w_dead_zero = (r_act_dead == '0);
        assign w_dt_done   = ({1'b0, r_dcnt} + c_dead_one) >= {1'b0, r_act_dead};

        always_comb begin
            w_next      = r_state;
            w_dcnt_next = r_dcnt;
            if (!w_run) begin
                w_next = ST_OFF;
            end else begin
                case (r_state)
                    ST_OFF: w_next = ST_LO_ON;
                    ST_LO_ON: begin
                        if (w_raw) begin
                            w_next      = w_dead_zero ? ST_HI_ON : ST_DT_RISE;
                            w_dcnt_next = '0;
                        end
                    end
                    ST_DT_RISE: begin
                        if (!w_raw) begin
                            w_next = ST_LO_ON;
                        end else if (w_dt_done) begin
                            w_next = ST_HI_ON;
                        end else begin
                            w_dcnt_next = r_dcnt + 1'b1;
                        end
                    end
                    ST_HI_ON: begin
                        if (!w_raw) begin
                            w_next      = w_dead_zero ? ST_LO_ON : ST_DT_FALL;
                            w_dcnt_next = '0;
                        end
                    end
                    ST_DT_FALL: begin
                        if (w_raw) begin
                            w_next = ST_HI_ON;
                        end else if (w_dt_done) begin
                            w_next = ST_LO_ON;
                        end else begin
                            w_dcnt_next = r_dcnt + 1'b1;
                        end
                    end
                    default: w_next = ST_OFF;
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state <= ST_OFF;
                r_dcnt  <= '0;
                r_hi    <= 1'b0;
                r_lo    <= 1'b0;
            end else begin
                r_state <= w_next;
                r_dcnt  <= w_dcnt_next;
                r_hi    <= (w_next == ST_HI_ON);
                r_lo    <= (w_next == ST_LO_ON);
            end
        end

        assign pwm_hi_o[gi] = r_hi & ~w_kill;
        assign pwm_lo_o[gi] = r_lo & ~w_kill;
    end

endmodule
`default_nettype wire

// File: doc/pwm_dt_core.md
Name: pwm_dt_core

Overview:
- Next-generation PWM core: N phase-offset channels, each driving a complementary high-side/low-side output pair with programmable dead-time insertion.
- Config is double-buffered and swaps only at the period boundary, so there are no glitched periods.
- Sits below a register-file wrapper that owns the bus/alerts. Parallel config inputs only, no bus logic inside.

Parameters:
- NChannels, 4, number of complementary channel pairs (1..16)
- CntDw, 16, period/duty/phase counter width
- DeadDw, 8, dead-time counter width

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- en_i  in  1  core enable; low = safe state
- period_i  in  CntDw  period value P; period = P+1 cycles
- duty_i  in  NChannels*CntDw  per-channel high time, cycles
- phase_i  in  NChannels*CntDw  per-channel phase offset, cycles
- dead_i  in  DeadDw  dead time D, cycles, shared by all channels
- cfg_update_i  in  1  single-cycle pulse; latches all config inputs into staging
- cfg_pending_o  out  1  staged config not yet active
- cycle_start_o  out  1  one-cycle pulse at start of each period
- pwm_hi_o  out  NChannels  high-side drive
- pwm_lo_o  out  NChannels  low-side drive

Behaviour:
- Reset: counter 0, all outputs 0, staging and active config 0, channel FSMs in OFF, cfg_pending_o 0.
- Config path:
  - cfg_update_i copies the inputs into staging and sets cfg_pending_o.
  - While en_i=1, staging moves to active on the wrap cycle (cnt==P_active -> 0) and cfg_pending_o clears that same cycle.
  - While en_i=0, the swap happens on the cycle after the update.
  - A second update while pending overwrites staging; still one swap.
  - Update coincident with wrap: the new values go to staging, not active; pending stays 1 until the next wrap.
- Counter:
  - en_i=1: cnt increments 0..P_active, then wraps to 0.
  - P=0: every cycle is a wrap.
  - en_i=0: cnt held at 0.
- Raw per-channel compare (combinational, CntDw+1 bit arithmetic):
  - ph = min(phase, P).
  - s = cnt-ph if cnt>=ph, else cnt+P+1-ph.
  - raw = (s < duty).
  - duty=0: raw always 0.
  - duty>P: raw always 1 (100%).
- Channel FSM states: OFF, LO_ON, DT_RISE, HI_ON, DT_FALL. Dead counter dcnt is DeadDw bits.
  - OFF: hi=0, lo=0. Entered on en_i=0 from any state. On en_i=1, go to LO_ON.
  - LO_ON: lo=1. If raw=1: go to DT_RISE with dcnt=0, or straight to HI_ON if D=0.
  - DT_RISE: hi=0, lo=0. dcnt increments.
    - dcnt==D-1: go to HI_ON.
    - raw falls first: go back to LO_ON. A pulse shorter than D never drives hi.
  - HI_ON: hi=1. If raw=0: go to DT_FALL, or straight to LO_ON if D=0.
  - DT_FALL: mirror image of DT_RISE.
    - dcnt==D-1: go to LO_ON.
    - raw rises again first: go back to HI_ON.
- Outputs are registered from the FSM state: 1-cycle latency from counter to pins.
- pwm_hi_o[i] & pwm_lo_o[i] must never both be 1 in any cycle.
- cycle_start_o is registered and is 1 in the cycle after cnt==0 while en_i=1.
- en_i dropping mid-period: next cycle all outputs are 0 and cnt=0. Re-enable restarts at cnt=0, channels in LO_ON.
- Reset mid-operation: immediate asynchronous return to the reset values above.

Optional Feature:
- Macro: PWM_DT_FAULT_EN.
- When defined:
  - Adds input fault_i (1 bit), input fault_clr_i (1 bit) and output fault_o (1 bit).
  - fault_i high sets a sticky fault latch asynchronously to the counter state but sampled on clk_i. Takes effect the cycle after sampling.
  - While latched: all channels are in OFF, both outputs 0, fault_o=1, and cnt is held at 0.
  - fault_clr_i clears the latch only when fault_i=0. Operation then resumes from LO_ON at cnt=0.
- When undefined: no ports added, no latch; behaviour is exactly as above.

Test Plan:
- P=9, duty0=5, phase0=0, D=0, en=1 -> hi0 high 5 cycles of every 10, lo0 the other 5, cycle_start_o once per 10 cycles.
- P=9, duty1=3, phase1=8 -> hi1 high at cnt 8,9,0, offset 1 cycle by register latency.
- P=19, duty=10, D=2 -> hi high 8 cycles, lo high 8 cycles, two 2-cycle dead gaps per period; hi&lo never both 1.
- P=9, duty=1, D=3 -> hi never asserts; lo drops for 1 cycle and returns. Also duty=0 gives lo constant, duty=12 gives hi constant.
- Update mid-period (P=9 -> P=4, cnt=3) -> cfg_pending_o=1 until cnt wraps after 9; next period is 5 cycles; pending clears on the wrap.
- en_i low at cnt=6 then high -> outputs 0 the next cycle, restart at cnt=0. rst_i mid-period -> all outputs 0 immediately.
